// File: rtl/snake_pkg.sv
// Shared types for the snake body engine: heading codes, FSM states and
// heading helpers.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SCAN,
    ST_DONE
  } state_e;

  // Heading that would fold the head back onto its own neck.
  function automatic dir_e opposite(dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_IDLE;
    endcase
  endfunction

  // Only the four real headings can steer; IDLE and codes 5..7 are ignored.
  function automatic logic dir_valid(logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

endpackage

// File: rtl/snake_ring.sv
// Segment ring: MAX_LEN (x,y) cells, one write port at the new head slot,
// one indexed read port for the self-collision scan and a flat view of every
// entry for the parallel pixel comparators.
module snake_ring #(
  parameter int MAX_LEN = 32,
  parameter int XW      = 7,
  parameter int YW      = 6,
  parameter int PW      = 5,
  parameter int X_START = 40,
  parameter int Y_START = 30
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        we,
  input  logic [PW-1:0]               waddr,
  input  logic [XW-1:0]               wx,
  input  logic [YW-1:0]               wy,
  input  logic [PW-1:0]               raddr,
  output logic [XW-1:0]               rx,
  output logic [YW-1:0]               ry,
  output logic [MAX_LEN-1:0][XW-1:0]  cells_x,
  output logic [MAX_LEN-1:0][YW-1:0]  cells_y
);

  // Storage: every entry collapses onto the start cell on clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        cells_x[i] <= XW'(X_START);
        cells_y[i] <= YW'(Y_START);
      end
    end else if (we) begin
      cells_x[waddr] <= wx;
      cells_y[waddr] <= wy;
    end
  end

  assign rx = cells_x[raddr];
  assign ry = cells_y[raddr];

endmodule

// File: rtl/snake_engine.sv
// Grid-based snake body engine. Advances the head one cell per accepted tick,
// handles growth, wall wrap/collision, reversal rejection and registered
// head/body pixel hits for the colour mux.
// Optional sequential self-collision scan: define SNAKE_SELF_COLLISION_EN.
module snake_engine
  import snake_pkg::*;
#(
  parameter int BIT       = 10,
  parameter int CELL_LOG2 = 3,
  parameter int GRID_W    = 80,
  parameter int GRID_H    = 60,
  parameter int MAX_LEN   = 32,
  parameter int X_START   = 40,
  parameter int Y_START   = 30,
  parameter int WRAP      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           restart,
  input  logic                           tick,
  input  logic [2:0]                     direction,
  input  logic                           grow,
  input  logic [BIT-1:0]                 x_pos,
  input  logic [BIT-1:0]                 y_pos,
  output logic                           head_hit,
  output logic                           body_hit,
  output logic [$clog2(GRID_W)-1:0]      head_x,
  output logic [$clog2(GRID_H)-1:0]      head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           busy,
  output logic                           move_done,
  output logic                           self_collision,
  output logic                           wall_collision
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = BIT - CELL_LOG2;
  localparam logic [XW:0] GW = (XW+1)'(GRID_W);
  localparam logic [YW:0] GH = (YW+1)'(GRID_H);

  logic                        clear;
  state_e                      state_q, state_d;
  dir_e                        heading_q;
  logic [PW-1:0]               head_ptr_q;
  logic [LW-1:0]               len_q, len_next;
  logic                        grow_pend_q, grow_any;
  logic                        wall_col_q, move_done_q;
  logic                        head_hit_q, body_hit_q;
  logic                        collided, tick_ok, commit, wall_hit;
  logic [XW:0]                 nx;
  logic [YW:0]                 ny;
  logic                        off_grid;
  logic [MAX_LEN-1:0][XW-1:0]  cells_x;
  logic [MAX_LEN-1:0][YW-1:0]  cells_y;
  logic [XW-1:0]               cur_x, rd_x;
  logic [YW-1:0]               cur_y, rd_y;
  logic [PW-1:0]               rd_addr;
  logic [CW-1:0]               pix_x, pix_y;
  logic                        pix_in;
  logic [MAX_LEN-1:0]          seg_hit;
  logic                        unused_pix;

  assign clear = reset | restart;

  snake_ring #(
    .MAX_LEN (MAX_LEN),
    .XW      (XW),
    .YW      (YW),
    .PW      (PW),
    .X_START (X_START),
    .Y_START (Y_START)
  ) u_ring (
    .clk     (clk),
    .clear   (clear),
    .we      (commit),
    .waddr   (head_ptr_q - PW'(1)),
    .wx      (nx[XW-1:0]),
    .wy      (ny[YW-1:0]),
    .raddr   (rd_addr),
    .rx      (rd_x),
    .ry      (rd_y),
    .cells_x (cells_x),
    .cells_y (cells_y)
  );

  assign cur_x = cells_x[head_ptr_q];
  assign cur_y = cells_y[head_ptr_q];

`ifdef SNAKE_SELF_COLLISION_EN
  logic [LW-1:0] scan_age_q;
  logic          self_col_q, scan_hit, scan_last;
  assign rd_addr  = head_ptr_q + scan_age_q[PW-1:0];
  assign collided = wall_col_q | self_col_q;
`else
  logic unused_rd;
  assign rd_addr   = '0;
  assign unused_rd = ^{rd_x, rd_y};
  assign collided  = wall_col_q;
`endif

  assign tick_ok  = (state_q == ST_IDLE) && tick && !collided;
  assign grow_any = grow_pend_q | grow;
  assign len_next = (grow_any && (len_q != LW'(MAX_LEN))) ? len_q + LW'(1) : len_q;

  // Next head cell, one bit wider so both under- and overflow show as >= size.
  always_comb begin
    nx = {1'b0, cur_x};
    ny = {1'b0, cur_y};
    case (heading_q)
      DIR_UP:   ny = ny - (YW+1)'(1);
      DIR_DOWN: ny = ny + (YW+1)'(1);
      DIR_LEFT: nx = nx - (XW+1)'(1);
      default:  nx = nx + (XW+1)'(1);
    endcase
    off_grid = 1'b0;
    if (nx >= GW) begin
      if (WRAP != 0) nx = (nx == GW) ? '0 : GW - (XW+1)'(1);
      else           off_grid = 1'b1;
    end
    if (ny >= GH) begin
      if (WRAP != 0) ny = (ny == GH) ? '0 : GH - (YW+1)'(1);
      else           off_grid = 1'b1;
    end
  end

  // Move sequencer next-state and strobes.
  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    wall_hit = 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
    scan_hit  = 1'b0;
    scan_last = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (tick_ok) state_d = ST_MOVE;
      ST_MOVE: begin
        if (off_grid) begin
          wall_hit = 1'b1;
          state_d  = ST_DONE;
        end else begin
          commit = 1'b1;
`ifdef SNAKE_SELF_COLLISION_EN
          state_d = (len_next >= LW'(3)) ? ST_SCAN : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_SCAN: begin
`ifdef SNAKE_SELF_COLLISION_EN
        // Length 3 has no age to test; the guard lets it fall straight out.
        scan_hit  = (scan_age_q < len_q) && (rd_x == cur_x) && (rd_y == cur_y);
        scan_last = (scan_age_q >= len_q - LW'(1));
        if (scan_hit || scan_last) state_d = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, heading, ring pointer, length and sticky wall flag.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      heading_q   <= DIR_RIGHT;
      head_ptr_q  <= '0;
      len_q       <= LW'(1);
      grow_pend_q <= 1'b0;
      wall_col_q  <= 1'b0;
      move_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_done_q <= (state_q == ST_DONE);
      if (tick_ok && dir_valid(direction) && (dir_e'(direction) != opposite(heading_q)))
        heading_q <= dir_e'(direction);
      if (commit) begin
        head_ptr_q  <= head_ptr_q - PW'(1);
        len_q       <= len_next;
        grow_pend_q <= 1'b0;
      end else if (grow) begin
        grow_pend_q <= 1'b1;
      end
      if (wall_hit) wall_col_q <= 1'b1;
    end
  end

`ifdef SNAKE_SELF_COLLISION_EN
  // Scan index walks ages 3.. after each commit; a hit latches self collision.
  always_ff @(posedge clk) begin
    if (clear) begin
      scan_age_q <= LW'(3);
      self_col_q <= 1'b0;
    end else begin
      if (commit)                  scan_age_q <= LW'(3);
      else if (state_q == ST_SCAN) scan_age_q <= scan_age_q + LW'(1);
      if (scan_hit) self_col_q <= 1'b1;
    end
  end
  assign self_collision = self_col_q;
`else
  assign self_collision = 1'b0;
`endif

  // Pixel cell and one comparator per ring entry, qualified by its age.
  assign pix_x      = x_pos[BIT-1:CELL_LOG2];
  assign pix_y      = y_pos[BIT-1:CELL_LOG2];
  assign pix_in     = (pix_x < CW'(GRID_W)) && (pix_y < CW'(GRID_H));
  assign unused_pix = ^{x_pos[CELL_LOG2-1:0], y_pos[CELL_LOG2-1:0]};

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    logic [PW-1:0] age;
    assign age        = PW'(i) - head_ptr_q;
    assign seg_hit[i] = (age != '0) && (LW'(age) < len_q) &&
                        (CW'(cells_x[i]) == pix_x) && (CW'(cells_y[i]) == pix_y);
  end

  // Registered hits so the colour mux sees a clean one-cycle-late result.
  always_ff @(posedge clk) begin
    if (clear) begin
      head_hit_q <= 1'b0;
      body_hit_q <= 1'b0;
    end else begin
      head_hit_q <= pix_in && (CW'(cur_x) == pix_x) && (CW'(cur_y) == pix_y);
      body_hit_q <= pix_in && (|seg_hit);
    end
  end

  assign head_hit       = head_hit_q;
  assign body_hit       = body_hit_q;
  assign head_x         = cur_x;
  assign head_y         = cur_y;
  assign length         = len_q;
  assign busy           = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign move_done      = move_done_q;
  assign wall_collision = wall_col_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a WRAP=0 and a WRAP=1 instance share stimulus and
// are checked against a history-list model of the snake.
`timescale 1ns/1ps
module tb_snake_engine;

  localparam int ML = 32;
`ifdef SNAKE_SELF_COLLISION_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, restart, tick, grow;
  logic [2:0] direction;
  logic [9:0] x_pos, y_pos;
  logic [1:0] head_hit_o, body_hit_o, busy_o, move_done_o, self_o, wall_o;
  logic [1:0][6:0] head_x_o;
  logic [1:0][5:0] head_y_o;
  logic [1:0][5:0] len_o;

  always #5 clk = ~clk;

  snake_engine #(.WRAP(0)) dut (
    .clk(clk), .reset(reset), .restart(restart), .tick(tick),
    .direction(direction), .grow(grow), .x_pos(x_pos), .y_pos(y_pos),
    .head_hit(head_hit_o[0]), .body_hit(body_hit_o[0]),
    .head_x(head_x_o[0]), .head_y(head_y_o[0]), .length(len_o[0]),
    .busy(busy_o[0]), .move_done(move_done_o[0]),
    .self_collision(self_o[0]), .wall_collision(wall_o[0]));

  snake_engine #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .restart(restart), .tick(tick),
    .direction(direction), .grow(grow), .x_pos(x_pos), .y_pos(y_pos),
    .head_hit(head_hit_o[1]), .body_hit(body_hit_o[1]),
    .head_x(head_x_o[1]), .head_y(head_y_o[1]), .length(len_o[1]),
    .busy(busy_o[1]), .move_done(move_done_o[1]),
    .self_collision(self_o[1]), .wall_collision(wall_o[1]));

  // Model: hx/hy[m][k] is where the head was k moves ago (k=0 is the head).
  int hx[2][ML];
  int hy[2][ML];
  int mlen[2], mdx[2], mdy[2];
  bit mpend[2], mself[2], mwall[2];
  int vectors = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ddx(int d);
    return (d == 3) ? -1 : (d == 4) ? 1 : 0;
  endfunction
  function automatic int ddy(int d);
    return (d == 1) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < ML; k++) begin hx[m][k] = 40; hy[m][k] = 30; end
      mlen[m] = 1; mdx[m] = 1; mdy[m] = 0;
      mpend[m] = 0; mself[m] = 0; mwall[m] = 0;
    end
  endtask

  task automatic model_move(input int m, input int d);
    int nx, ny;
    if (mself[m] || mwall[m]) return;
    if (d >= 1 && d <= 4 && !(ddx(d) == -mdx[m] && ddy(d) == -mdy[m])) begin
      mdx[m] = ddx(d); mdy[m] = ddy(d);
    end
    nx = hx[m][0] + mdx[m];
    ny = hy[m][0] + mdy[m];
    if (m == 1) begin
      nx = (nx + 80) % 80;
      ny = (ny + 60) % 60;
    end else if (nx < 0 || nx >= 80 || ny < 0 || ny >= 60) begin
      mwall[m] = 1;
      return;
    end
    for (int k = ML - 1; k > 0; k--) begin hx[m][k] = hx[m][k-1]; hy[m][k] = hy[m][k-1]; end
    hx[m][0] = nx; hy[m][0] = ny;
    if (mpend[m]) begin
      if (mlen[m] < ML) mlen[m]++;
      mpend[m] = 0;
    end
    if (SCAN_ON)
      for (int k = 3; k < mlen[m]; k++)
        if (hx[m][k] == nx && hy[m][k] == ny) mself[m] = 1;
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_hx%0d", tag, m), head_x_o[m], hx[m][0]);
      chk($sformatf("%s_hy%0d", tag, m), head_y_o[m], hy[m][0]);
      chk($sformatf("%s_len%0d", tag, m), len_o[m], mlen[m]);
      chk($sformatf("%s_wall%0d", tag, m), wall_o[m], mwall[m]);
      chk($sformatf("%s_self%0d", tag, m), self_o[m], mself[m]);
      chk($sformatf("%s_busy%0d", tag, m), busy_o[m], 0);
    end
  endtask

  task automatic do_move(input int d);
    int seen[2];
    int expd[2];
    for (int m = 0; m < 2; m++) begin
      seen[m] = 0;
      expd[m] = (mself[m] || mwall[m]) ? 0 : 1;
    end
    @(negedge clk); direction = 3'(d); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    for (int c = 0; c < ML + 8; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (move_done_o[m]) seen[m]++;
    end
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("done%0d", m), seen[m], expd[m]);
      model_move(m, d);
    end
    check_all("mv");
  endtask

  task automatic grow_pulse();
    @(negedge clk); grow = 1'b1;
    @(negedge clk); grow = 1'b0;
    mpend[0] = 1; mpend[1] = 1;
  endtask

  task automatic do_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    model_reset();
  endtask

  task automatic pix_check(input int px, input int py);
    int cx, cy;
    bit in_g, eh, eb;
    @(negedge clk); x_pos = 10'(px); y_pos = 10'(py);
    @(negedge clk);
    cx = px >> 3; cy = py >> 3;
    in_g = (cx < 80) && (cy < 60);
    for (int m = 0; m < 2; m++) begin
      eh = in_g && hx[m][0] == cx && hy[m][0] == cy;
      eb = 0;
      for (int k = 1; k < mlen[m]; k++) if (hx[m][k] == cx && hy[m][k] == cy) eb = 1;
      eb = eb && in_g;
      chk($sformatf("pix_head%0d", m), head_hit_o[m], eh);
      chk($sformatf("pix_body%0d", m), body_hit_o[m], eb);
    end
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; tick = 1'b0; grow = 1'b0;
    direction = 3'd0; x_pos = '0; y_pos = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("rst");
    chk("rst_done", move_done_o, 0);
    chk("rst_hits", {head_hit_o, body_hit_o}, 0);

    // First move, cycle by cycle: commit at N+1, move_done after N+2.
    @(negedge clk); direction = 3'd4; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("n_busy", busy_o[0], 0);
    chk("n_hx", head_x_o[0], 40);
    @(negedge clk);
    chk("n1_busy", busy_o[0], 1);
    chk("n1_hx", head_x_o[0], 41);
    chk("n1_done", move_done_o[0], 0);
    @(negedge clk);
    chk("n2_done", move_done_o[0], 1);
    chk("n2_busy", busy_o[0], 0);
    @(negedge clk);
    chk("n3_done", move_done_o[0], 0);
    model_move(0, 4); model_move(1, 4);
    check_all("first");

    // Reversal rejected.
    do_move(3);
    chk("rev_hx", head_x_o[0], 42);

    // Growth, with the body cell (42,30) lit one cycle after the pixel.
    grow_pulse();
    do_move(4);
    chk("grow_len", len_o[0], 2);
    pix_check(336, 240);
    chk("grow_body", body_hit_o[0], 1);
    do_move(4);
    do_move(4);
    chk("grow_len_hold", len_o[0], 2);

    // Wall: WRAP=0 latches collision and freezes, WRAP=1 wraps to column 0.
    for (int i = 0; i < 80 && hx[0][0] < 79; i++) do_move(4);
    chk("edge_hx", head_x_o[0], 79);
    do_move(4);
    chk("wall_flag", wall_o[0], 1);
    chk("wall_hx", head_x_o[0], 79);
    chk("wrap_hx", head_x_o[1], 0);
    do_move(4);
    chk("wrap_hx2", head_x_o[1], 1);
    do_restart();
    check_all("rst2");

    // Square path back onto age 4 of a length-5 snake.
    repeat (4) begin grow_pulse(); do_move(4); end
    do_move(4); do_move(2); do_move(3); do_move(1);
    chk("self_sq", self_o[0], SCAN_ON);

    // Restart while the move is still in flight.
    do_restart();
    repeat (7) begin grow_pulse(); do_move(4); end
    @(negedge clk); direction = 3'd4; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy_o[0], 1);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    model_reset();
    chk("mid_len", len_o[0], 1);
    chk("mid_done", move_done_o[0], 0);
    check_all("mid");

    // Randomized walk with growth, invalid codes and pixel probes.
    for (int it = 0; it < 150; it++) begin
      int k;
      if ((mself[0] || mwall[0]) && (mself[1] || mwall[1])) do_restart();
      if ($urandom_range(0, 3) == 0) grow_pulse();
      do_move(int'($urandom_range(0, 7)));
      if (it % 4 == 0) begin
        k = int'($urandom_range(0, mlen[1] - 1));
        pix_check(hx[1][k] * 8 + int'($urandom_range(0, 7)),
                  hy[1][k] * 8 + int'($urandom_range(0, 7)));
        pix_check(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
